ddr_out_reg: RTL and testbench



---
 rtl/ddr_out_pkg.sv | 27 ++
 rtl/ddr_edge_flop.sv | 61 ++++++
 rtl/ddr_out_reg.sv | 91 +++++++++
 tb/tb_ddr_out_reg.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_out_pkg.sv
// Shared constants and the per-bit r/s/ce priority rule used by both edge flops
// of the DDR output register.
package ddr_out_pkg;

  localparam string SR_SYNC  = "SYNC";
  localparam string SR_ASYNC = "ASYNC";

  // Reset beats set, set beats load, otherwise hold the current output bit.
  function automatic logic next_val(
    input logic r,
    input logic s,
    input logic ce,
    input logic d,
    input logic cur
  );
    if (r) begin
      return 1'b0;
    end else if (s) begin
      return 1'b1;
    end else if (ce) begin
      return d;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/ddr_edge_flop.sv
// One edge of the DDR output pair. Stores (next output ^ partner flop) so that
// the XOR of both flops always equals the current output.
module ddr_edge_flop
  import ddr_out_pkg::*;
#(
  parameter int unsigned      WIDTH    = 1,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter string            SRTYPE   = SR_SYNC,
  parameter bit               NEG_EDGE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             r,
  input  logic             s,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] partner,
  output logic [WIDTH-1:0] val
);

  localparam bit ASYNC_SR = (SRTYPE == SR_ASYNC);

  logic [WIDTH-1:0] cur_out;
  logic [WIDTH-1:0] flop_d;
  logic [WIDTH-1:0] flop_q;

  // cur_out is the value the pin currently shows; a hold must reproduce it.
  always_comb begin
    cur_out = flop_q ^ partner;
    if (ASYNC_SR && r) begin
      cur_out = '0;
    end else if (ASYNC_SR && s) begin
      cur_out = '1;
    end
    flop_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      flop_d[i] = next_val(r, s, ce, d[i], cur_out[i]) ^ partner[i];
    end
  end

  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flop_q <= INIT;
      end else begin
        flop_q <= flop_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flop_q <= INIT;
      end else begin
        flop_q <= flop_d;
      end
    end
  end

  assign val = flop_q;

endmodule

// File: rtl/ddr_out_reg.sv
// Dual-data-rate output register: d0 launched on the rising edge, d1 on the falling
// edge. Optional tristate request port enabled with `define DDR_OUT_REG_TRISTATE_EN.
module ddr_out_reg
  import ddr_out_pkg::*;
#(
  parameter int unsigned      WIDTH  = 1,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter string            SRTYPE = SR_SYNC
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             r,
  input  logic             s,
`ifdef DDR_OUT_REG_TRISTATE_EN
  input  logic             oe,
  output logic             q_t,
`endif
  output logic [WIDTH-1:0] q
);

  localparam bit ASYNC_SR = (SRTYPE == SR_ASYNC);

  logic [WIDTH-1:0] rise_val;
  logic [WIDTH-1:0] fall_val;

  // The rising flop carries INIT so that the XOR of the pair equals INIT in reset.
  ddr_edge_flop #(
    .WIDTH   (WIDTH),
    .INIT    (INIT),
    .SRTYPE  (SRTYPE),
    .NEG_EDGE(1'b0)
  ) u_rise (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .ce     (ce),
    .r      (r),
    .s      (s),
    .d      (d0),
    .partner(fall_val),
    .val    (rise_val)
  );

  ddr_edge_flop #(
    .WIDTH   (WIDTH),
    .INIT    ('0),
    .SRTYPE  (SRTYPE),
    .NEG_EDGE(1'b1)
  ) u_fall (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .ce     (ce),
    .r      (r),
    .s      (s),
    .d      (d1),
    .partner(rise_val),
    .val    (fall_val)
  );

  always_comb begin
    q = rise_val ^ fall_val;
    if (ASYNC_SR && r) begin
      q = '0;
    end else if (ASYNC_SR && s) begin
      q = '1;
    end
  end

`ifdef DDR_OUT_REG_TRISTATE_EN
  logic t_d;
  logic t_q;

  // r and s both request high-Z, so they share the "set" slot of the rule.
  always_comb begin
    t_d = next_val(1'b0, r | s, ce, ~oe, t_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      t_q <= 1'b1;
    end else begin
      t_q <= t_d;
    end
  end

  assign q_t = t_q;
`endif

endmodule

// File: tb/tb_ddr_out_reg.sv
// Self-checking bench for ddr_out_reg: a SYNC and an ASYNC instance share stimulus
// and are compared against a direct per-edge model of the output value.
module tb_ddr_out_reg;

  localparam int W = 16;
  localparam logic [W-1:0] INIT_S = 16'hA5C3;
  localparam logic [W-1:0] INIT_A = 16'h5A5A;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce    = 1'b0;
  logic         r     = 1'b0;
  logic         s     = 1'b0;
  logic [W-1:0] d0    = '0;
  logic [W-1:0] d1    = '0;
  logic [W-1:0] q_s;
  logic [W-1:0] q_a;
`ifdef DDR_OUT_REG_TRISTATE_EN
  logic         oe = 1'b0;
  logic         q_t_s;
  logic         q_t_a;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_s = INIT_S;
  logic [W-1:0] m_a = INIT_A;
  logic         m_t = 1'b1;

  always #5 clk = ~clk;

  ddr_out_reg #(.WIDTH(W), .INIT(INIT_S), .SRTYPE("SYNC")) dut_s (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .ce       (ce),
    .d0       (d0),
    .d1       (d1),
    .r        (r),
    .s        (s),
`ifdef DDR_OUT_REG_TRISTATE_EN
    .oe       (oe),
    .q_t      (q_t_s),
`endif
    .q        (q_s)
  );

  ddr_out_reg #(.WIDTH(W), .INIT(INIT_A), .SRTYPE("ASYNC")) dut_a (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .ce       (ce),
    .d0       (d0),
    .d1       (d1),
    .r        (r),
    .s        (s),
`ifdef DDR_OUT_REG_TRISTATE_EN
    .oe       (oe),
    .q_t      (q_t_a),
`endif
    .q        (q_a)
  );

  // Reference: the pin value itself, updated at every edge by the priority rule.
  always @(posedge clk or negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s = INIT_S;
      m_a = INIT_A;
      m_t = 1'b1;
    end else begin
      logic [W-1:0] d;
      d = clk ? d0 : d1;
      if (r) begin
        m_s = '0;
        m_a = '0;
      end else if (s) begin
        m_s = '1;
        m_a = '1;
      end else if (ce) begin
        m_s = d;
        m_a = d;
      end
      if (clk) begin
        if (r || s) m_t = 1'b1;
        else if (ce) m_t = ~oe_now();
      end
    end
  end

  function automatic logic oe_now();
`ifdef DDR_OUT_REG_TRISTATE_EN
    return oe;
`else
    return 1'b1;
`endif
  endfunction

  // What the ASYNC instance should show right now: r/s override the stored value.
  function automatic logic [W-1:0] disp_a();
    if (r) return '0;
    if (s) return '1;
    return m_a;
  endfunction

  task automatic step();
    @(posedge clk or negedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    d0 = 16'h0000;
    d1 = 16'hFFFF;
    @(posedge clk);
    #2;
    checks++;
    if (q_s !== INIT_S) begin errors++; $display("FAIL reset_hi_s: got %h exp %h", q_s, INIT_S); end
    checks++;
    if (q_a !== INIT_A) begin errors++; $display("FAIL reset_hi_a: got %h exp %h", q_a, INIT_A); end
    @(negedge clk);
    #2;
    checks++;
    if (q_s !== INIT_S) begin errors++; $display("FAIL reset_lo_s: got %h exp %h", q_s, INIT_S); end
    checks++;
    if (q_a !== INIT_A) begin errors++; $display("FAIL reset_lo_a: got %h exp %h", q_a, INIT_A); end
`ifdef DDR_OUT_REG_TRISTATE_EN
    checks++;
    if (q_t_s !== 1'b1) begin errors++; $display("FAIL reset_qt: got %b exp 1", q_t_s); end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] exp;
      step();
      exp = clk ? 16'h0000 : 16'hFFFF;
      checks++;
      if (q_s !== exp) begin errors++; $display("FAIL release_beat_s[%0d]: got %h exp %h", i, q_s, exp); end
      checks++;
      if (q_a !== exp) begin errors++; $display("FAIL release_beat_a[%0d]: got %h exp %h", i, q_a, exp); end
    end
  endtask

  task automatic test_clock_forward();
    d0 = '1;
    d1 = '0;
    ce = 1'b1;
    r = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] exp;
      step();
      exp = clk ? '1 : '0;
      checks++;
      if (q_s !== exp) begin errors++; $display("FAIL clk_fwd_s[%0d]: got %h exp %h", i, q_s, exp); end
      checks++;
      if (q_a[0] !== clk) begin errors++; $display("FAIL clk_fwd_a[%0d]: got %b exp %b", i, q_a[0], clk); end
    end
  endtask

  task automatic test_data_beats();
    @(negedge clk);
    #2;
    d0 = 16'h1234;
    d1 = 16'hABCD;
    step();
    checks++;
    if (q_s !== 16'h1234) begin errors++; $display("FAIL beat0: got %h exp 1234", q_s); end
    d0 = 16'h5678;
    step();
    checks++;
    if (q_s !== 16'hABCD) begin errors++; $display("FAIL beat1: got %h exp abcd", q_s); end
    d1 = 16'hEF01;
    step();
    checks++;
    if (q_s !== 16'h5678) begin errors++; $display("FAIL beat2: got %h exp 5678", q_s); end
    step();
    checks++;
    if (q_s !== 16'hEF01) begin errors++; $display("FAIL beat3: got %h exp ef01", q_s); end
  endtask

  task automatic test_enable();
    logic [W-1:0] nd;
    d0 = 16'h1234;
    d1 = 16'hABCD;
    step();
    step();
    checks++;
    if (q_s !== 16'hABCD) begin errors++; $display("FAIL en_pre: got %h exp abcd", q_s); end
    ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d0 = W'($urandom);
      d1 = W'($urandom);
      if (i == 3) begin
        d0 = 'x;
        d1 = 'x;
      end
      step();
      checks++;
      if (q_s !== 16'hABCD) begin errors++; $display("FAIL en_hold_s[%0d]: got %h exp abcd", i, q_s); end
      checks++;
      if (q_a !== 16'hABCD) begin errors++; $display("FAIL en_hold_a[%0d]: got %h exp abcd", i, q_a); end
    end
    nd = W'($urandom);
    d0 = nd;
    ce = 1'b1;
    step();
    checks++;
    if (q_s !== nd) begin errors++; $display("FAIL en_resume: got %h exp %h", q_s, nd); end
  endtask

  task automatic test_rs();
    logic [W-1:0] prev;
    prev = m_s;
    r = 1'b1;
    s = 1'b1;
    #1;
    checks++;
    if (q_a !== '0) begin errors++; $display("FAIL rs_async_imm: got %h exp 0000", q_a); end
    checks++;
    if (q_s !== prev) begin errors++; $display("FAIL rs_sync_wait: got %h exp %h", q_s, prev); end
    step();
    checks++;
    if (q_s !== '0) begin errors++; $display("FAIL rs_both: got %h exp 0000", q_s); end
    r = 1'b0;
    #1;
    checks++;
    if (q_a !== '1) begin errors++; $display("FAIL s_async_imm: got %h exp ffff", q_a); end
    checks++;
    if (q_s !== '0) begin errors++; $display("FAIL s_sync_wait: got %h exp 0000", q_s); end
    step();
    checks++;
    if (q_s !== '1) begin errors++; $display("FAIL s_edge: got %h exp ffff", q_s); end
    s = 1'b0;
    ce = 1'b0;
    step();
    step();
    checks++;
    if (q_s !== '1) begin errors++; $display("FAIL s_hold: got %h exp ffff", q_s); end
    r = 1'b1;
    #1;
    checks++;
    if (q_a !== '0) begin errors++; $display("FAIL r_mid_async: got %h exp 0000", q_a); end
    checks++;
    if (q_s !== '1) begin errors++; $display("FAIL r_mid_sync: got %h exp ffff", q_s); end
    step();
    checks++;
    if (q_s !== '0) begin errors++; $display("FAIL r_edge: got %h exp 0000", q_s); end
    r = 1'b0;
    ce = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      d0 = W'($urandom);
      d1 = W'($urandom);
      ce = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 7) == 0);
`ifdef DDR_OUT_REG_TRISTATE_EN
      oe = 1'($urandom_range(0, 1));
`endif
      #1;
      checks++;
      if (q_a !== disp_a()) begin errors++; $display("FAIL rnd_imm_a[%0d]: got %h exp %h", i, q_a, disp_a()); end
      step();
      checks++;
      if (q_s !== m_s) begin errors++; $display("FAIL rnd_s[%0d]: got %h exp %h", i, q_s, m_s); end
      checks++;
      if (q_a !== disp_a()) begin errors++; $display("FAIL rnd_a[%0d]: got %h exp %h", i, q_a, disp_a()); end
`ifdef DDR_OUT_REG_TRISTATE_EN
      checks++;
      if (q_t_s !== m_t) begin errors++; $display("FAIL rnd_qt[%0d]: got %b exp %b", i, q_t_s, m_t); end
`endif
    end
    r = 1'b0;
    s = 1'b0;
    ce = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    d0 = 16'h5678;
    d1 = W'($urandom);
    step();
    checks++;
    if (q_s !== 16'h5678) begin errors++; $display("FAIL ar_pre: got %h exp 5678", q_s); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q_s !== INIT_S) begin errors++; $display("FAIL ar_imm_s: got %h exp %h", q_s, INIT_S); end
    checks++;
    if (q_a !== INIT_A) begin errors++; $display("FAIL ar_imm_a: got %h exp %h", q_a, INIT_A); end
    for (int i = 0; i < 4; i++) begin
      d0 = W'($urandom);
      d1 = W'($urandom);
      step();
      checks++;
      if (q_s !== INIT_S) begin errors++; $display("FAIL ar_held[%0d]: got %h exp %h", i, q_s, INIT_S); end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (q_s !== (clk ? d0 : d1)) begin errors++; $display("FAIL ar_release: got %h exp %h", q_s, clk ? d0 : d1); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clock_forward();
    test_data_beats();
    test_enable();
    test_rs();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
